// File: rtl/fetch_unit_pkg.sv
// Shared picoMIPS definitions: default widths, opcodes, fetch FSM state
// encoding and the next-PC action codes used between fetch_unit and next_pc.
package fetch_unit_pkg;

  localparam int PSIZE_DEF = 6;
  localparam int ISIZE_DEF = 24;
  localparam int OPW       = 6;

  localparam logic [OPW-1:0] OP_NOP  = 6'b000000;
  localparam logic [OPW-1:0] OP_ADD  = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPW-1:0] OP_MUL  = 6'b000011;
  localparam logic [OPW-1:0] OP_MULI = 6'b000100;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000101;
  localparam logic [OPW-1:0] OP_JMP  = 6'b000110;
  localparam logic [OPW-1:0] OP_BRA  = 6'b000111;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INCR   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_STALL  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc: combinational next-fetch-address selection.
// Priority stall > absolute branch > relative branch > increment > hold.
// Decoder controls only count while the instruction register holds a real
// instruction; otherwise the unit just keeps fetching sequentially.
module next_pc
  import fetch_unit_pkg::*;
#(
  parameter int PSIZE = PSIZE_DEF
) (
  input  logic [PSIZE-1:0] fetch_pc_i,
  input  logic [PSIZE-1:0] instr_pc_i,
  input  logic [PSIZE-1:0] branch_addr_i,
  input  logic             instr_valid_i,
  input  logic             stall_i,
  input  logic             incr_i,
  input  logic             absbranch_i,
  input  logic             relbranch_i,
  output logic [PSIZE-1:0] pc_next_o,
  output logic [1:0]       pc_sel_o
);

  logic    abs_take;
  logic    rel_take;
  logic    incr_eff;
  pc_sel_e sel;

  assign abs_take = instr_valid_i & absbranch_i;
  assign rel_take = instr_valid_i & relbranch_i;
  assign incr_eff = ~instr_valid_i | incr_i;

  // Prioritised target selection; the relative sum is taken at PSIZE width,
  // which is the same as sign-extending the offset and wrapping mod 2^PSIZE.
  always_comb begin
    sel       = PC_HOLD;
    pc_next_o = fetch_pc_i;
    if (stall_i) begin
      sel = PC_STALL;
    end else if (abs_take) begin
      sel       = PC_BRANCH;
      pc_next_o = branch_addr_i;
    end else if (rel_take) begin
      sel       = PC_BRANCH;
      pc_next_o = instr_pc_i + branch_addr_i;
    end else if (incr_eff) begin
      sel       = PC_INCR;
      pc_next_o = fetch_pc_i + PSIZE'(1);
    end
  end

  assign pc_sel_o = sel;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for a synchronous program ROM.
//
// state | meaning
// FILL  | ROM pipeline priming; rom_addr = fetch_pc, registers frozen
// RUN   | rom_data = ROM[fetch_pc]; rom_addr tracks next fetch_pc
//
// The release of reset is registered once before FILL may count its
// priming cycle, so the first valid instruction (ROM[0]) lands on the
// third rising edge after release.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PSIZE = PSIZE_DEF,
  parameter int ISIZE = ISIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             PCincr,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [PSIZE-1:0] branch_addr,
  output logic [PSIZE-1:0] rom_addr,
  input  logic [ISIZE-1:0] rom_data,
  output logic [ISIZE-1:0] instr,
  output logic             instr_valid,
  output logic [PSIZE-1:0] instr_pc
);

  localparam logic [ISIZE-1:0] NOP_WORD = {OP_NOP, {(ISIZE-OPW){1'b0}}};

  fetch_state_e     state_q, state_d;
  logic             rel_q;
  logic [PSIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ISIZE-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [PSIZE-1:0] ipc_q, ipc_d;
  logic [PSIZE-1:0] pc_next;
  logic [1:0]       pc_sel;

  next_pc #(.PSIZE(PSIZE)) u_next_pc (
    .fetch_pc_i    (fetch_pc_q),
    .instr_pc_i    (ipc_q),
    .branch_addr_i (branch_addr),
    .instr_valid_i (valid_q),
    .stall_i       (stall),
    .incr_i        (PCincr),
    .absbranch_i   (PCabsbranch),
    .relbranch_i   (PCrelbranch),
    .pc_next_o     (pc_next),
    .pc_sel_o      (pc_sel)
  );

  // State register plus registered reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= 1'b1;
    end
  end

  // FILL lasts one non-stalled cycle once reset release has been seen.
  always_comb begin
    state_d = state_q;
    if (state_q == FILL && rel_q && !stall) begin
      state_d = RUN;
    end
  end

  // Register next-values and the ROM address for the current state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    ipc_d      = ipc_q;
    if (state_q == RUN) begin
      case (pc_sel_e'(pc_sel))
        PC_INCR: begin
          fetch_pc_d = pc_next;
          instr_d    = rom_data;
          valid_d    = 1'b1;
          ipc_d      = fetch_pc_q;
        end
        PC_BRANCH: begin
          fetch_pc_d = pc_next;
          instr_d    = NOP_WORD;
          valid_d    = 1'b0;
        end
        default: begin
        end
      endcase
    end
    rom_addr = fetch_pc_d;
  end

  // Fetch datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= '0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      ipc_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      ipc_q      <= ipc_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = ipc_q;

endmodule
